keypad_scan: RTL and testbench

//  Scans a 3-column x 4-row matrix keypad and debounces it. Emits single-cycle
//  one-hot digit strobes (num_input) and a '#' strobe (set_time) for the

---
 rtl/keypad_scan.sv | 141 ++++++++++++++
 tb/tb_keypad_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// Scanner and debouncer for a 3x4 matrix keypad. Produces a debounced key code
// and one-cycle strobes for digits, '*' and '#'.
module keypad_scan #(
  parameter int SCAN_HOLD = 2,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] num_input,
  output logic       set_time,
  output logic       star_key,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int HW = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [3:0]    NO_KEY     = 4'd15;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(SCAN_HOLD - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  logic [HW-1:0] hold;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [3:0]    candidate;
  logic [SW-1:0] stable_cnt;
  logic          code_changed;

  logic          sample;
  logic          frame_end;
  logic [2:0]    row_hits;
  logic [3:0]    code_next;
  logic [1:0]    cnt_next;
  logic [3:0]    frame_code;
  logic [3:0]    cand_next;
  logic [SW-1:0] stable_next;
  logic          accept;

  function automatic logic [3:0] pos_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r != 2'd3) begin
      code = 4'({2'b00, r} * 4'd3 + {2'b00, c} + 4'd1);
    end else begin
      case (c)
        2'd0:    code = 4'd10;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end
    return code;
  endfunction

  assign key_col  = 3'b001 << col;
  assign key_held = (key_code != NO_KEY);

  // Fold this column's rows into the frame accumulator and run the debounce
  // decision; everything is committed only on sample / frame-end cycles.
  always_comb begin
    sample    = (hold == HOLD_LAST);
    frame_end = sample && (col == 2'd2);
    row_hits  = '0;
    code_next = acc_code;
    for (int i = 0; i < 4; i++) begin
      if (key_row[i]) begin
        row_hits  = row_hits + 3'd1;
        code_next = pos_code(2'(i), col);
      end
    end
    if (({1'b0, acc_cnt} + row_hits) >= 3'd2) begin
      cnt_next = 2'd2;
    end else begin
      cnt_next = acc_cnt + row_hits[1:0];
    end
    frame_code = (cnt_next == 2'd1) ? code_next : NO_KEY;

    if (frame_code == candidate) begin
      cand_next   = candidate;
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end else begin
      cand_next   = frame_code;
      stable_next = SW'(1);
    end
    accept = frame_end && (stable_next == STABLE_MAX) && (cand_next != key_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold         <= '0;
      col          <= '0;
      acc_cnt      <= '0;
      acc_code     <= NO_KEY;
      candidate    <= NO_KEY;
      stable_cnt   <= '0;
      key_code     <= NO_KEY;
      code_changed <= 1'b0;
      num_input    <= '0;
      set_time     <= 1'b0;
      star_key     <= 1'b0;
    end else begin
      if (sample) begin
        hold <= '0;
        col  <= (col == 2'd2) ? 2'd0 : col + 2'd1;
      end else begin
        hold <= hold + 1'b1;
      end

      if (frame_end) begin
        acc_cnt    <= '0;
        acc_code   <= NO_KEY;
        candidate  <= cand_next;
        stable_cnt <= stable_next;
      end else if (sample) begin
        acc_cnt  <= cnt_next;
        acc_code <= code_next;
      end

      code_changed <= accept;
      if (accept) begin
        key_code <= cand_next;
      end

      // Strobes follow key_code by one cycle; a release decodes to nothing.
      num_input <= '0;
      set_time  <= 1'b0;
      star_key  <= 1'b0;
      if (code_changed) begin
        if (key_code < 4'd10) begin
          num_input <= 10'd1 << key_code;
        end else if (key_code == 4'd10) begin
          star_key <= 1'b1;
        end else if (key_code == 4'd11) begin
          set_time <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan with a frame-level reference
// model and a strobe scoreboard.
module tb_keypad_scan;

  localparam int SCAN_HOLD = 2;
  localparam int DEBOUNCE  = 4;
  localparam int FRAME     = 3 * SCAN_HOLD;
  localparam logic [3:0] NO_KEY = 4'd15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] num_input;
  logic       set_time;
  logic       star_key;
  logic [3:0] key_code;
  logic       key_held;

  keypad_scan #(.SCAN_HOLD(SCAN_HOLD), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .num_input(num_input),
    .set_time (set_time),
    .star_key (star_key),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    int         at;
  } strobe_t;

  logic [11:0] pressed = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [3:0]  model_code = NO_KEY;
  logic [3:0]  history[$];
  strobe_t     expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal switch matrix: a pressed key connects its row to its driven column.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && pressed[r*3+c]) key_row[r] = 1'b1;
  end

  function automatic logic [3:0] code_of_pos(input int p);
    logic [3:0] codes [12];
    codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
    return codes[p];
  endfunction

  function automatic int pos_of_code(input int code);
    if (code == 0) return 10;
    if (code == 10) return 9;
    if (code == 11) return 11;
    return code - 1;
  endfunction

  function automatic logic [3:0] frame_code(input logic [11:0] mask);
    if ($countones(mask) != 1) return NO_KEY;
    for (int p = 0; p < 12; p++)
      if (mask[p]) return code_of_pos(p);
    return NO_KEY;
  endfunction

  function automatic logic [11:0] key_mask(input int code);
    logic [11:0] m;
    m = '0;
    m[pos_of_code(code)] = 1'b1;
    return m;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A key is accepted once the last DEBOUNCE frames all read the same code.
  task automatic apply_frame(input logic [11:0] mask);
    logic [3:0] fc;
    logic       all_same;
    pressed = mask;
    for (int k = 0; k < FRAME; k++) begin
      check_output("key_col", key_col, 1 << (k / SCAN_HOLD));
      @(posedge clk);
      @(negedge clk);
    end
    fc = frame_code(mask);
    history.push_back(fc);
    if (history.size() > DEBOUNCE) void'(history.pop_front());
    all_same = (history.size() == DEBOUNCE);
    foreach (history[i]) if (history[i] != fc) all_same = 1'b0;
    if (all_same && fc != model_code) begin
      model_code = fc;
      if (fc != NO_KEY) expq.push_back('{code: fc, at: cyc + 1});
    end
    check_output("key_code", key_code, model_code);
    check_output("key_held", key_held, model_code != NO_KEY);
  endtask

  task automatic apply_frames(input logic [11:0] mask, input int n);
    for (int i = 0; i < n; i++) apply_frame(mask);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    history.delete();
    expq.delete();
    model_code = NO_KEY;
    check_output("reset_key_col", key_col, 1);
    check_output("reset_key_code", key_code, NO_KEY);
    check_output("reset_key_held", key_held, 0);
    check_output("reset_strobes", {num_input, set_time, star_key}, 0);
  endtask

  task automatic apply_stimulus_random(input int segments);
    int kind;
    int len;
    int a;
    int b;
    for (int s = 0; s < segments; s++) begin
      kind = $urandom_range(9, 0);
      len  = $urandom_range(7, 1);
      a    = $urandom_range(11, 0);
      b    = $urandom_range(11, 0);
      if (kind == 0) begin
        pressed = '0;
        do_reset($urandom_range(3, 1));
      end else if (kind <= 5) begin
        apply_frames(12'd1 << a, len);
      end else if (kind == 6) begin
        apply_frames('0, len);
      end else if (kind == 7) begin
        apply_frames((12'd1 << a) | (12'd1 << b), len);
      end else begin
        for (int i = 0; i < len; i++) apply_frame((i % 2 == 0) ? (12'd1 << a) : '0);
      end
    end
  endtask

  // Scoreboard monitor: every strobe seen must match the oldest expected one.
  always @(negedge clk) begin
    int      n;
    int      c;
    strobe_t e;
    n = $countones(num_input) + int'(set_time) + int'(star_key);
    if (n != 0) begin
      check_output("strobe_onehot", n, 1);
      c = 15;
      if (star_key) c = 10;
      else if (set_time) c = 11;
      else for (int d = 0; d < 10; d++) if (num_input[d]) c = d;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe: got code %0d, expected no strobe (cycle %0d)", c, cyc);
      end else begin
        e = expq.pop_front();
        check_output("strobe_code", c, e.code);
        check_output("strobe_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    do_reset(3);
    apply_frames('0, 2);
    apply_frames(key_mask(5), 10);
    apply_frames('0, 5);
    apply_frames(key_mask(11), 6);
    apply_frames('0, 4);
    for (int i = 0; i < 12; i++) apply_frame((i % 2 == 0) ? key_mask(7) : '0);
    apply_frames('0, 4);
    apply_frames(key_mask(1) | key_mask(2), 8);
    apply_frames(key_mask(1), 6);
    apply_frames('0, 5);
    apply_frames(key_mask(0), 3);
    do_reset(1);
    apply_frames(key_mask(0), 6);
    apply_frames('0, 4);
    apply_frames(key_mask(5), 5);
    apply_frames(key_mask(6), 5);
    apply_frames(key_mask(10), 5);
    apply_frames('0, 4);
    apply_stimulus_random(40);
    apply_frames('0, 5);
    repeat (3) @(negedge clk);
    check_output("pending_strobes", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
